// File: rtl/gnss_search_scheduler.sv
// Search scheduler: picks the next eligible SV round-robin, launches it on the lowest free
// tracking channel, and on a strong enough correlation hands the SV over to that channel.
module gnss_search_scheduler #(
  parameter int          NCH     = 4,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [31:0]        sv_mask,
  input  logic [31:0]        threshold,
  input  logic [NCH-1:0]     chan_release,
  input  logic               search_busy,
  input  logic               search_done,
  input  logic [31:0]        search_corr,
  output logic               search_start,
  output logic [4:0]         search_sv,
  output logic [5:0]         search_channel,
  output logic [NCH-1:0]     chan_start,
  output logic [NCH-1:0]     chan_busy,
  output logic [5*NCH-1:0]   chan_sv,
  output logic               timeout_err
);

  typedef enum logic [2:0] {IDLE, PICK, LAUNCH, WAIT_BUSY, WAIT_DONE, DECIDE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  ptr;
  logic [4:0]  cur_sv;
  logic [2:0]  cur_ch;
  logic [31:0] corr;
  logic [23:0] cnt;

  logic [31:0] held;
  logic [31:0] elig;
  logic        pick_found;
  logic [4:0]  pick_sv;
  logic [4:0]  scan_idx;
  logic        free_found;
  logic [2:0]  free_ch;
  logic        waiting;
  logic        done_seen;
  logic        timed_out;
  logic        acq_ok;

  // Round-robin scan from ptr; descending offsets so the nearest eligible SV wins.
  always_comb begin
    held       = '0;
    pick_found = 1'b0;
    pick_sv    = '0;
    scan_idx   = '0;
    free_found = 1'b0;
    free_ch    = '0;
    for (int k = 0; k < NCH; k++)
      if (chan_busy[k]) held[chan_sv[5*k +: 5]] = 1'b1;
    elig = sv_mask & ~held;
    for (int i = 31; i >= 0; i--) begin
      scan_idx = ptr + 5'(i);
      if (elig[scan_idx]) begin
        pick_found = 1'b1;
        pick_sv    = scan_idx;
      end
    end
    for (int k = NCH - 1; k >= 0; k--)
      if (!chan_busy[k]) begin
        free_found = 1'b1;
        free_ch    = 3'(k);
      end
  end

  assign waiting   = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign done_seen = waiting && search_done;
  assign timed_out = waiting && !search_done && (cnt + 24'd1 == TIMEOUT);
  assign acq_ok    = (state == DECIDE) && (corr >= threshold);

  assign search_start = (state == LAUNCH);

  always_comb begin
    chan_start = '0;
    for (int k = 0; k < NCH; k++)
      chan_start[k] = acq_ok && (cur_ch == 3'(k));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable && !search_busy && free_found) state_nxt = PICK;
      PICK:      state_nxt = pick_found ? LAUNCH : IDLE;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (done_seen)        state_nxt = DECIDE;
        else if (timed_out)   state_nxt = IDLE;
        else if (search_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_seen)      state_nxt = DECIDE;
        else if (timed_out) state_nxt = IDLE;
      end
      DECIDE:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      chan_busy      <= '0;
      chan_sv        <= '0;
      search_sv      <= '0;
      search_channel <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == PICK && pick_found) begin
        search_sv      <= pick_sv;
        search_channel <= {3'b000, free_ch};
      end
      if (state == LAUNCH)
        cnt <= '0;
      else if (waiting)
        cnt <= cnt + 24'd1;
      if (timed_out) begin
        timeout_err <= 1'b1;
        ptr         <= cur_sv + 5'd1;
      end
      if (state == DECIDE)
        ptr <= cur_sv + 5'd1;
      // A new assignment overrides a release of the same channel in the same cycle.
      chan_busy <= (chan_busy & ~chan_release) | chan_start;
      for (int k = 0; k < NCH; k++)
        if (chan_start[k]) chan_sv[5*k +: 5] <= cur_sv;
    end
  end

  always_ff @(posedge clk) begin
    if (state == PICK && pick_found) begin
      cur_sv <= pick_sv;
      cur_ch <= free_ch;
    end
    if (done_seen)
      corr <= search_corr;
  end

endmodule

// File: tb/tb_gnss_search_scheduler.sv
// Randomized bench for gnss_search_scheduler against a transaction-level model of
// channel occupancy, SV ownership and the round-robin pointer.
module tb_gnss_search_scheduler;
  localparam int          NCH = 4;
  localparam logic [23:0] TMO = 24'd16;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [31:0]      sv_mask;
  logic [31:0]      threshold;
  logic [NCH-1:0]   chan_release;
  logic             search_busy;
  logic             search_done;
  logic [31:0]      search_corr;
  logic             search_start;
  logic [4:0]       search_sv;
  logic [5:0]       search_channel;
  logic [NCH-1:0]   chan_start;
  logic [NCH-1:0]   chan_busy;
  logic [5*NCH-1:0] chan_sv;
  logic             timeout_err;

  gnss_search_scheduler #(.NCH(NCH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sv_mask(sv_mask), .threshold(threshold),
    .chan_release(chan_release), .search_busy(search_busy), .search_done(search_done),
    .search_corr(search_corr), .search_start(search_start), .search_sv(search_sv),
    .search_channel(search_channel), .chan_start(chan_start), .chan_busy(chan_busy),
    .chan_sv(chan_sv), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  bit         m_busy [NCH];
  logic [4:0] m_slot [NCH];
  int         m_ptr;
  bit         m_terr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_busy[k] = 1'b0;
      m_slot[k] = '0;
    end
    m_ptr  = 0;
    m_terr = 1'b0;
  endtask

  function automatic void predict(output bit found, output int sv, output int ch);
    bit held [32];
    for (int s = 0; s < 32; s++) held[s] = 1'b0;
    for (int k = 0; k < NCH; k++) if (m_busy[k]) held[m_slot[k]] = 1'b1;
    found = 1'b0;
    sv    = 0;
    ch    = -1;
    for (int k = NCH - 1; k >= 0; k--) if (!m_busy[k]) ch = k;
    if (ch < 0) return;
    for (int o = 0; o < 32; o++) begin
      int s;
      s = (m_ptr + o) % 32;
      if (sv_mask[s] && !held[s]) begin
        found = 1'b1;
        sv    = s;
        break;
      end
    end
  endfunction

  function automatic logic [NCH-1:0] exp_busy();
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_busy[k];
    return v;
  endfunction

  function automatic logic [5*NCH-1:0] exp_sv();
    logic [5*NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[5*k +: 5] = m_slot[k];
    return v;
  endfunction

  task automatic run_round(input int r, input int mode);
    bit             found;
    bit             seen;
    bit             ok;
    int             esv;
    int             ech;
    int             starts;
    int             lat;
    logic [31:0]    c;
    logic [NCH-1:0] rel;
    predict(found, esv, ech);
    if (!found) begin
      starts = 0;
      repeat (6) begin
        tick();
        if (search_start) starts++;
      end
      check("blocked_no_launch", starts, 0);
      chan_release = '1;
      tick();
      chan_release = '0;
      sv_mask = $urandom | 32'h1;
      for (int k = 0; k < NCH; k++) m_busy[k] = 1'b0;
      check("release_all_busy", chan_busy, '0);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (search_start) seen = 1'b1;
    end
    check("launch_seen", seen, 1);
    if (!seen) return;
    check("search_sv", search_sv, esv);
    check("search_channel", search_channel, ech);

    if (mode == 1) begin
      for (int i = 1; i <= 16; i++) begin
        tick();
        if (i == 1) check("start_pulse", search_start, 0);
      end
      check("tmo_not_yet", timeout_err, m_terr);
      tick();
      check("tmo_flag", timeout_err, 1);
      m_terr = 1'b1;
      m_ptr  = (esv + 1) % 32;
      check("tmo_busy", chan_busy, exp_busy());
      return;
    end

    if (mode == 2) begin
      search_busy = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      search_busy = 1'b0;
      tick();
      rst = 1'b0;
      enable = 1'b0;
      model_reset();
      check("rst_busy", chan_busy, '0);
      check("rst_chan_sv", chan_sv, '0);
      check("rst_search_sv", search_sv, 0);
      check("rst_search_ch", search_channel, 0);
      check("rst_tmo", timeout_err, 0);
      check("rst_start", search_start, 0);
      starts = 0;
      search_done = 1'b1;
      search_corr = 32'hFFFF_FFFF;
      tick();
      search_done = 1'b0;
      repeat (3) begin
        if (chan_start != '0) starts++;
        tick();
      end
      check("late_done_ignored", starts, 0);
      check("late_done_busy", chan_busy, '0);
      enable = 1'b1;
      return;
    end

    if (r % 7 == 3) enable = 1'b0;
    lat = $urandom_range(0, 4);
    case ($urandom_range(0, 3))
      0:       c = threshold;
      1:       c = threshold - 32'd1;
      2:       c = $urandom;
      default: c = threshold + 32'($urandom_range(1, 1000));
    endcase
    ok = (c >= threshold);
    search_busy = 1'b0;
    tick();
    check("start_pulse", search_start, 0);
    repeat (lat) begin
      search_busy = 1'b1;
      tick();
    end
    search_busy = 1'b0;
    search_done = 1'b1;
    search_corr = c;
    tick();
    search_done = 1'b0;
    search_corr = $urandom;
    check("chan_start", chan_start, ok ? (1 << ech) : 0);
    rel = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
    if (r % 5 == 1) rel[ech] = 1'b1;
    chan_release = rel;
    tick();
    chan_release = '0;
    for (int k = 0; k < NCH; k++) if (rel[k]) m_busy[k] = 1'b0;
    if (ok) begin
      m_busy[ech] = 1'b1;
      m_slot[ech] = 5'(esv);
    end
    m_ptr = (esv + 1) % 32;
    check("chan_busy", chan_busy, exp_busy());
    check("chan_sv", chan_sv, exp_sv());
    check("chan_start_pulse", chan_start, '0);
    enable = 1'b1;
    if (r == 30) begin
      enable = 1'b0;
      starts = 0;
      repeat (8) begin
        tick();
        if (search_start) starts++;
      end
      check("enable_block", starts, 0);
      enable = 1'b1;
    end
    if ($urandom_range(0, 3) == 0) sv_mask = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom & $urandom);
    if ($urandom_range(0, 3) == 0) threshold = $urandom;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    sv_mask      = '0;
    threshold    = '0;
    chan_release = '0;
    search_busy  = 1'b0;
    search_done  = 1'b0;
    search_corr  = '0;
    model_reset();
    repeat (3) tick();
    check("reset_start", search_start, 0);
    check("reset_sv", search_sv, 0);
    check("reset_ch", search_channel, 0);
    check("reset_chan_start", chan_start, '0);
    check("reset_chan_busy", chan_busy, '0);
    check("reset_chan_sv", chan_sv, '0);
    check("reset_tmo", timeout_err, 0);
    rst       = 1'b0;
    sv_mask   = 32'h5;
    threshold = 32'd100;
    enable    = 1'b1;
    for (int r = 0; r < 90; r++) begin
      int mode;
      if (r == 55) mode = 2;
      else if (r == 12 || $urandom_range(0, 11) == 0) mode = 1;
      else mode = 0;
      run_round(r, mode);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
